// File: rtl/hub75_bcm_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_bcm_scanner_pkg
//  Purpose  : Shared FSM encodings and frame-buffer word layout for the
//             HUB75 BCM scan engine.
//  Revision : 1.0 - initial release
// ============================================================================
package hub75_bcm_scanner_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SHIFT   = 2'd1;
    localparam logic [1:0] c_ST_LATCH   = 2'd2;
    localparam logic [1:0] c_ST_DISPLAY = 2'd3;

    // Field order inside rd_data, most significant first: {R0,G0,B0,R1,G1,B1}
    localparam int c_FLD_R0  = 0;
    localparam int c_FLD_G0  = 1;
    localparam int c_FLD_B0  = 2;
    localparam int c_FLD_R1  = 3;
    localparam int c_FLD_G1  = 4;
    localparam int c_FLD_B1  = 5;
    localparam int c_NUM_FLD = 6;

    function automatic int fld_lsb(input int fld, input int depth);
        return (c_NUM_FLD - 1 - fld) * depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_bcm_timer.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_bcm_timer
//  Purpose  : Bitplane display timer; loads BASE_TIME<<plane and flags the
//             final cycle of the count.
//  Revision : 1.0 - initial release
// ============================================================================
module hub75_bcm_timer #(
    parameter int BASE_TIME = 8,
    parameter int DEPTH     = 5,
    parameter int PL_W      = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PL_W-1:0] plane,
    output logic            done
);

    localparam int               CNT_W  = $clog2(BASE_TIME << (DEPTH - 1)) + 1;
    localparam logic [CNT_W-1:0] c_BASE = CNT_W'(BASE_TIME);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_BASE << plane;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign done = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hub75_bcm_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_bcm_scanner
//  Purpose  : HUB75 panel scan engine with binary-coded modulation, fed from
//             a synchronous frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module hub75_bcm_scanner
    import hub75_bcm_scanner_pkg::*;
#(
    parameter int COLS         = 64,
    parameter int SCAN_ROWS    = 16,
    parameter int DEPTH        = 5,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = 2,
    parameter int BASE_TIME    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enable,
    output logic [$clog2(SCAN_ROWS)+$clog2(COLS)-1:0] rd_addr,
    input  logic [6*DEPTH-1:0]                        rd_data,
    output logic [$clog2(SCAN_ROWS)-1:0]              sel,
    output logic                                     clkout,
    output logic                                     stb,
    output logic                                     oe,
    output logic                                     r0,
    output logic                                     g0,
    output logic                                     b0,
    output logic                                     r1,
    output logic                                     g1,
    output logic                                     b1,
    output logic                                     frame_start
);

    localparam int ROW_W = $clog2(SCAN_ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int PL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LC_W  = $clog2(LATCH_CYCLES + 1);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);
    localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  c_PH_HIGH  = PH_W'(CLK_DIV / 2);
    localparam logic [PL_W-1:0]  c_PL_LAST  = PL_W'(DEPTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(SCAN_ROWS - 1);
    localparam logic [LC_W-1:0]  c_LC_LAST  = LC_W'(LATCH_CYCLES - 1);

    logic [1:0]             r_state, w_state_nxt;
    logic [COL_W-1:0]       r_col, w_col_nxt;
    logic [PH_W-1:0]        r_phase, w_phase_nxt;
    logic [LC_W-1:0]        r_lcnt;
    logic [ROW_W-1:0]       r_row, w_row_nxt, w_row_after;
    logic [PL_W-1:0]        r_plane, w_plane_nxt;
    logic                   w_shift_last, w_latch_last, w_disp_done, w_timer_done;
    logic                   w_pix_start, w_shift_entry;
    logic [DEPTH-1:0]       w_field [c_NUM_FLD];
    logic [c_NUM_FLD-1:0]   w_bits;

    logic [ROW_W+COL_W-1:0] r_rd_addr;
    logic [ROW_W-1:0]       r_sel;
    logic                   r_clkout, r_stb, r_oe, r_frame_start;
    logic [c_NUM_FLD-1:0]   r_rgb;

    for (genvar f = 0; f < c_NUM_FLD; f++) begin : g_fld
        assign w_field[f] = rd_data[fld_lsb(f, DEPTH) +: DEPTH];
        assign w_bits[f]  = w_field[f][w_plane_nxt];
    end

    hub75_bcm_timer #(
        .BASE_TIME (BASE_TIME),
        .DEPTH     (DEPTH),
        .PL_W      (PL_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_latch_last),
        .plane (r_plane),
        .done  (w_timer_done)
    );

    assign w_shift_last = (r_state == c_ST_SHIFT) && (r_col == c_COL_LAST) && (r_phase == c_PH_LAST);
    assign w_latch_last = (r_state == c_ST_LATCH) && (r_lcnt == c_LC_LAST);
    assign w_disp_done  = (r_state == c_ST_DISPLAY) && w_timer_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (enable)       w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT:   if (w_shift_last) w_state_nxt = c_ST_LATCH;
            c_ST_LATCH:   if (w_latch_last) w_state_nxt = c_ST_DISPLAY;
            c_ST_DISPLAY: if (w_timer_done) w_state_nxt = enable ? c_ST_SHIFT : c_ST_IDLE;
            default:                        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Pixel/phase counters describe the current cycle; they rest at zero outside SHIFT
    always_comb begin
        w_phase_nxt = '0;
        w_col_nxt   = '0;
        if (r_state == c_ST_SHIFT) begin
            if (r_phase == c_PH_LAST) begin
                w_col_nxt = r_col + COL_W'(1);
            end else begin
                w_phase_nxt = r_phase + PH_W'(1);
                w_col_nxt   = r_col;
            end
        end
    end

    always_comb begin
        w_row_after = r_row;
        if (r_plane == c_PL_LAST) begin
            w_row_after = (r_row == c_ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end
        w_row_nxt   = w_disp_done ? w_row_after : r_row;
        w_plane_nxt = r_plane;
        if (w_disp_done) begin
            w_plane_nxt = (r_plane == c_PL_LAST) ? '0 : r_plane + PL_W'(1);
        end
    end

    assign w_pix_start   = (w_state_nxt == c_ST_SHIFT) && (w_phase_nxt == '0);
    assign w_shift_entry = (w_state_nxt == c_ST_SHIFT) && (r_state != c_ST_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_col   <= '0;
            r_lcnt  <= '0;
            r_row   <= '0;
            r_plane <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_col   <= w_col_nxt;
            r_lcnt  <= (r_state == c_ST_LATCH) ? r_lcnt + LC_W'(1) : '0;
            r_row   <= w_row_nxt;
            r_plane <= w_plane_nxt;
        end
    end

    // Address runs one pixel ahead; at LATCH entry it parks on column 0 of the next pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr     <= '0;
            r_sel         <= '0;
            r_clkout      <= 1'b0;
            r_stb         <= 1'b0;
            r_oe          <= 1'b1;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_oe          <= (w_state_nxt != c_ST_DISPLAY);
            r_stb         <= (w_state_nxt == c_ST_LATCH);
            r_clkout      <= (w_state_nxt == c_ST_SHIFT) && (w_phase_nxt >= c_PH_HIGH);
            r_frame_start <= w_shift_entry && (w_row_nxt == '0) && (w_plane_nxt == '0);
            if (w_pix_start) begin
                r_rgb     <= w_bits;
                r_rd_addr <= {w_row_nxt, w_col_nxt + COL_W'(1)};
            end else if (w_shift_last) begin
                r_rd_addr <= {w_row_after, {COL_W{1'b0}}};
            end
            if (w_shift_last) begin
                r_sel <= r_row;
            end
        end
    end

    assign rd_addr     = r_rd_addr;
    assign sel         = r_sel;
    assign clkout      = r_clkout;
    assign stb         = r_stb;
    assign oe          = r_oe;
    assign frame_start = r_frame_start;
    assign r0          = r_rgb[c_FLD_R0];
    assign g0          = r_rgb[c_FLD_G0];
    assign b0          = r_rgb[c_FLD_B0];
    assign r1          = r_rgb[c_FLD_R1];
    assign g1          = r_rgb[c_FLD_G1];
    assign b1          = r_rgb[c_FLD_B1];

endmodule
`default_nettype wire

// File: tb/tb_hub75_bcm_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hub75_bcm_scanner
//  Purpose  : Self-checking bench for hub75_bcm_scanner against a cycle-level
//             reference of the panel waveform.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_bcm_scanner;

    localparam int COLS         = 4;
    localparam int SCAN_ROWS    = 2;
    localparam int DEPTH        = 2;
    localparam int CLK_DIV      = 2;
    localparam int LATCH_CYCLES = 2;
    localparam int BASE_TIME    = 4;
    localparam int ROW_W        = $clog2(SCAN_ROWS);
    localparam int COL_W        = $clog2(COLS);
    localparam int SHIFT_CYC    = COLS * CLK_DIV;
    localparam int VW           = 10 + ROW_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   enable = 1'b0;
    logic [ROW_W+COL_W-1:0] rd_addr;
    logic [6*DEPTH-1:0]     rd_data = '0;
    logic [ROW_W-1:0]       sel;
    logic                   clkout, stb, oe, r0, g0, b0, r1, g1, b1, frame_start;

    logic [6*DEPTH-1:0]     mem [SCAN_ROWS*COLS];
    logic [ROW_W-1:0]       exp_sel = '0;
    logic [COLS-1:0]        seen_r0, seen_b1;
    int                     checks = 0;
    int                     errors = 0;
    int                     fs_cnt = 0, fs_since = 0, fs_last_gap = -1;

    hub75_bcm_scanner #(
        .COLS         (COLS),
        .SCAN_ROWS    (SCAN_ROWS),
        .DEPTH        (DEPTH),
        .CLK_DIV      (CLK_DIV),
        .LATCH_CYCLES (LATCH_CYCLES),
        .BASE_TIME    (BASE_TIME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sel         (sel),
        .clkout      (clkout),
        .stb         (stb),
        .oe          (oe),
        .r0          (r0),
        .g0          (g0),
        .b0          (b0),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: one clock of read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (rst) begin
            fs_cnt = 0; fs_since = 0; fs_last_gap = -1;
        end else begin
            fs_since++;
            if (frame_start) begin
                if (fs_cnt > 0) fs_last_gap = fs_since;
                fs_since = 0;
                fs_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // {r0,g0,b0,r1,g1,b1} for a pixel: component k (R0 = most significant field) at bit `plane`
    function automatic logic [5:0] exp_pix(input int row, input int col, input int plane);
        logic [6*DEPTH-1:0] w;
        logic [5:0]         b;
        w = mem[row*COLS + col];
        for (int k = 0; k < 6; k++) b[k] = w[k*DEPTH + plane];
        return b;
    endfunction

    function automatic logic [VW-1:0] observed();
        return {frame_start, oe, stb, clkout, sel, r0, g0, b0, r1, g1, b1};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < SCAN_ROWS*COLS; i++) mem[i] = (6*DEPTH)'($urandom);
    endtask

    // Holds reset, then releases it at a negedge so the next sample is the first SHIFT cycle
    task automatic restart(input logic en);
        rst = 1'b1;
        enable = en;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_sel = '0;
    endtask

    task automatic run_rowplane(input int row, input int plane, input bit new_frame, input int drop_at);
        int             period;
        int             rises;
        logic           prev_clk;
        logic [VW-1:0]  e_vec, a_vec;
        period   = SHIFT_CYC + LATCH_CYCLES + (BASE_TIME << plane);
        rises    = 0;
        prev_clk = 1'b0;
        for (int i = 0; i < period; i++) begin
            logic             e_oe, e_stb, e_clk, e_fs;
            logic [ROW_W-1:0] e_sel;
            logic [5:0]       e_pix;
            @(negedge clk);
            if (i < SHIFT_CYC) begin
                e_pix = exp_pix(row, i / CLK_DIV, plane);
                e_clk = (i % CLK_DIV) >= CLK_DIV / 2;
                e_oe  = 1'b1;
                e_stb = 1'b0;
                e_sel = exp_sel;
            end else if (i < SHIFT_CYC + LATCH_CYCLES) begin
                e_pix = exp_pix(row, COLS - 1, plane);
                e_clk = 1'b0;
                e_oe  = 1'b1;
                e_stb = 1'b1;
                e_sel = ROW_W'(row);
            end else begin
                e_pix = exp_pix(row, COLS - 1, plane);
                e_clk = 1'b0;
                e_oe  = 1'b0;
                e_stb = 1'b0;
                e_sel = ROW_W'(row);
            end
            e_fs  = new_frame && (i == 0);
            e_vec = {e_fs, e_oe, e_stb, e_clk, e_sel, e_pix};
            a_vec = observed();
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL scan row%0d plane%0d cyc%0d {fs,oe,stb,clk,sel,rgb}: got %b expected %b",
                         row, plane, i, a_vec, e_vec);
            end
            if (i < SHIFT_CYC && (i % CLK_DIV) == 0) begin
                seen_r0[i / CLK_DIV] = r0;
                seen_b1[i / CLK_DIV] = b1;
            end
            if (clkout && !prev_clk) rises++;
            prev_clk = clkout;
            if (i == drop_at) enable = 1'b0;
        end
        exp_sel = ROW_W'(row);
        checks++;
        if (rises != COLS) begin
            errors++;
            $display("FAIL clkout_rises row%0d plane%0d: got %0d expected %0d", row, plane, rises, COLS);
        end
    endtask

    task automatic test_reset();
        fill_random();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (observed() !== {1'b0, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}, 6'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", observed(),
                     {1'b0, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}, 6'b0});
        end
        checks++;
        if (rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr);
        end
    endtask

    task automatic test_shift_directed();
        int r0_vals [COLS] = '{3, 0, 1, 2};
        fill_random();
        for (int c = 0; c < COLS; c++) begin
            mem[c][6*DEPTH-1 -: DEPTH] = DEPTH'(r0_vals[c]);
            mem[c][DEPTH-1:0]          = (c == 2) ? 2'b10 : 2'b00;
        end
        restart(1'b1);
        run_rowplane(0, 0, 1'b1, -1);
        checks++;
        if (seen_r0 !== 4'b0101) begin
            errors++;
            $display("FAIL r0_seq_plane0: got %b expected %b", seen_r0, 4'b0101);
        end
        checks++;
        if (seen_b1 !== 4'b0000) begin
            errors++;
            $display("FAIL b1_seq_plane0: got %b expected %b", seen_b1, 4'b0000);
        end
        run_rowplane(0, 1, 1'b0, -1);
        checks++;
        if (seen_r0 !== 4'b1001) begin
            errors++;
            $display("FAIL r0_seq_plane1: got %b expected %b", seen_r0, 4'b1001);
        end
        checks++;
        if (seen_b1 !== 4'b0100) begin
            errors++;
            $display("FAIL b1_seq_plane1: got %b expected %b", seen_b1, 4'b0100);
        end
        run_rowplane(1, 0, 1'b0, -1);
        run_rowplane(1, 1, 1'b0, -1);
        run_rowplane(0, 0, 1'b1, -1);
        #1;
        checks++;
        if (fs_cnt != 2 || fs_last_gap != 64) begin
            errors++;
            $display("FAIL frame_start_gap: got count %0d gap %0d expected count 2 gap 64", fs_cnt, fs_last_gap);
        end
    endtask

    task automatic test_random_frames();
        fill_random();
        restart(1'b1);
        for (int fr = 0; fr < 3; fr++)
            for (int row = 0; row < SCAN_ROWS; row++)
                for (int p = 0; p < DEPTH; p++)
                    run_rowplane(row, p, (row == 0) && (p == 0), -1);
    endtask

    task automatic test_enable_drop();
        fill_random();
        restart(1'b1);
        run_rowplane(0, 0, 1'b1, $urandom_range(0, SHIFT_CYC - 1));
        for (int i = 0; i < 8; i++) begin
            logic [VW-1:0] e_vec;
            @(negedge clk);
            e_vec = {1'b0, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}, exp_pix(0, COLS - 1, 0)};
            checks++;
            if (observed() !== e_vec) begin
                errors++;
                $display("FAIL idle_after_drop cyc%0d: got %b expected %b", i, observed(), e_vec);
            end
        end
        enable = 1'b1;
        run_rowplane(0, 1, 1'b0, -1);
        run_rowplane(1, 0, 1'b0, -1);
    endtask

    task automatic test_reset_midscan();
        fill_random();
        restart(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (clkout !== 1'b1) begin
            errors++;
            $display("FAIL shift_clkout_high: got %b expected 1", clkout);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({oe, clkout} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_shift {oe,clkout}: got %b expected 10", {oe, clkout});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_sel = '0;
        repeat (12) @(negedge clk);
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL display_oe_low: got %b expected 0", oe);
        end
        rst = 1'b1;
        enable = 1'b0;
        #1;
        checks++;
        if ({oe, clkout, stb} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_display {oe,clkout,stb}: got %b expected 100", {oe, clkout, stb});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== {1'b0, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}, 6'b0} || rd_addr !== '0) begin
                errors++;
                $display("FAIL idle_after_reset cyc%0d: got %b addr %0h expected %b addr 0", i, observed(),
                         rd_addr, {1'b0, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}, 6'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_directed();
        test_random_frames();
        test_enable_drop();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
